acs_array_64: RTL and testbench

Add-compare-select stage of the rate-1/2, K=7 Viterbi decoder, downstream of the 64 per-state branch-metric units. Each accepted received symbol pair is turned into 2-bit Hamming branch metrics for every transition. All 64 path metrics are updated in one cycle. One survivor-decision bit per state goes to the traceback memory. Path metrics are renormalised in place, so the registers never overflow.

---
 rtl/viterbi_pkg.sv | 21 ++
 rtl/acs_node.sv | 27 ++
 rtl/acs_array_64.sv | 150 +++++++++++++++
 tb/tb_acs_array_64.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants and encoder helper for the K=7, rate-1/2
// Viterbi decoder (generators 171/133 octal).
package viterbi_pkg;

  localparam int K       = 7;
  localparam int NSTATES = 64;

  localparam logic [6:0] G0 = 7'b1111001;
  localparam logic [6:0] G1 = 7'b1011011;

  localparam int PM_W_DEF    = 8;
  localparam int PM_INIT_DEF = 64;

  // Expected encoder outputs {c1,c0} when input u is shifted into state p.
  function automatic logic [1:0] enc_out(input logic [5:0] p, input logic u);
    logic [6:0] reg7;
    reg7 = {u, p};
    return {^(reg7 & G1), ^(reg7 & G0)};
  endfunction

endpackage

// File: rtl/acs_node.sv
// acs_node: combinational add-compare-select for one trellis state.
// Ties resolve to the even predecessor (decision 0).
module acs_node
  import viterbi_pkg::*;
#(
  parameter int PM_W = PM_W_DEF
) (
  input  logic [PM_W-1:0] i_pm0,
  input  logic [PM_W-1:0] i_pm1,
  input  logic [1:0]      i_bm0,
  input  logic [1:0]      i_bm1,
  output logic [PM_W:0]   o_pm,
  output logic            o_dec
);

  logic [PM_W:0] w_m0;
  logic [PM_W:0] w_m1;

  // Extend by one bit so the add can never wrap, then keep the smaller sum.
  always_comb begin
    w_m0  = {1'b0, i_pm0} + (PM_W+1)'(i_bm0);
    w_m1  = {1'b0, i_pm1} + (PM_W+1)'(i_bm1);
    o_dec = (w_m1 < w_m0);
    o_pm  = o_dec ? w_m1 : w_m0;
  end

endmodule

// File: rtl/acs_array_64.sv
// acs_array_64: 64-state add-compare-select stage with in-place metric
// renormalisation. Define ACS64_BEST_STATE_EN to build the minimum-metric
// search that drives best_valid / best_state / best_pm.
module acs_array_64
  import viterbi_pkg::*;
#(
  parameter int PM_W    = PM_W_DEF,
  parameter int PM_INIT = PM_INIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init,
  input  logic              i_rx_valid,
  input  logic [1:0]        i_rx_pair,
  output logic              o_dec_valid,
  output logic [63:0]       o_dec_bits,
  output logic              o_norm,
  output logic              o_best_valid,
  output logic [5:0]        o_best_state,
  output logic [PM_W-1:0]   o_best_pm
);

  localparam logic [PM_W-1:0] PM_INIT_V = PM_W'(PM_INIT);

  logic [PM_W-1:0]    r_pm [NSTATES];
  logic               r_dec_valid;
  logic [63:0]        r_dec_bits;
  logic               r_norm;

  logic [PM_W:0]      w_sel [NSTATES];
  logic [PM_W-1:0]    w_wb  [NSTATES];
  logic [NSTATES-1:0] w_dec;
  logic [NSTATES-1:0] w_high;
  logic               w_norm;

  for (genvar n = 0; n < NSTATES; n++) begin : g_acs
    localparam logic [5:0] P0 = 6'((n % 32) * 2);
    localparam logic [5:0] P1 = 6'((n % 32) * 2 + 1);
    localparam logic       U  = 1'(n / 32);
    localparam logic [1:0] C0 = enc_out(P0, U);
    localparam logic [1:0] C1 = enc_out(P1, U);

    logic [1:0] w_bm0;
    logic [1:0] w_bm1;

    assign w_bm0 = {1'b0, i_rx_pair[0] ^ C0[0]} + {1'b0, i_rx_pair[1] ^ C0[1]};
    assign w_bm1 = {1'b0, i_rx_pair[0] ^ C1[0]} + {1'b0, i_rx_pair[1] ^ C1[1]};

    acs_node #(.PM_W(PM_W)) u_node (
      .i_pm0 (r_pm[P0]),
      .i_pm1 (r_pm[P1]),
      .i_bm0 (w_bm0),
      .i_bm1 (w_bm1),
      .o_pm  (w_sel[n]),
      .o_dec (w_dec[n])
    );

    assign w_high[n] = w_sel[n][PM_W] | w_sel[n][PM_W-1];
  end

  assign w_norm = &w_high;

  // Writeback value: drop the top half-range bit everywhere once all metrics have reached it.
  always_comb begin
    for (int s = 0; s < NSTATES; s++) begin
      w_wb[s] = w_sel[s][PM_W-1:0];
      if (w_norm) begin
        w_wb[s][PM_W-1] = 1'b0;
      end
    end
  end

  // Metric registers and decision outputs; init wins over a same-cycle symbol.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < NSTATES; s++) begin
        r_pm[s] <= (s == 0) ? '0 : PM_INIT_V;
      end
      r_dec_valid <= 1'b0;
      r_dec_bits  <= '0;
      r_norm      <= 1'b0;
    end else if (i_init) begin
      for (int s = 0; s < NSTATES; s++) begin
        r_pm[s] <= (s == 0) ? '0 : PM_INIT_V;
      end
      r_dec_valid <= 1'b0;
      r_norm      <= 1'b0;
    end else if (i_rx_valid) begin
      for (int s = 0; s < NSTATES; s++) begin
        r_pm[s] <= w_wb[s];
      end
      r_dec_valid <= 1'b1;
      r_dec_bits  <= w_dec;
      r_norm      <= w_norm;
    end else begin
      r_dec_valid <= 1'b0;
      r_norm      <= 1'b0;
    end
  end

  assign o_dec_valid = r_dec_valid;
  assign o_dec_bits  = r_dec_bits;
  assign o_norm      = r_norm;

`ifdef ACS64_BEST_STATE_EN
  logic [PM_W-1:0] w_min_val [NSTATES];
  logic [5:0]      w_min_idx [NSTATES];
  logic            r_best_valid;
  logic [5:0]      r_best_state;
  logic [PM_W-1:0] r_best_pm;

  // Pairwise minimum tree; the left (lower-index) operand wins ties.
  always_comb begin
    for (int s = 0; s < NSTATES; s++) begin
      w_min_val[s] = r_pm[s];
      w_min_idx[s] = 6'(s);
    end
    for (int step = 1; step < NSTATES; step = step * 2) begin
      for (int s = 0; s < NSTATES; s = s + 2 * step) begin
        if (w_min_val[s+step] < w_min_val[s]) begin
          w_min_val[s] = w_min_val[s+step];
          w_min_idx[s] = w_min_idx[s+step];
        end
      end
    end
  end

  // Register the minimum one cycle behind the metrics it was taken from.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_best_valid <= 1'b0;
      r_best_state <= '0;
      r_best_pm    <= '0;
    end else begin
      r_best_valid <= r_dec_valid;
      r_best_state <= w_min_idx[0];
      r_best_pm    <= w_min_val[0];
    end
  end

  assign o_best_valid = r_best_valid;
  assign o_best_state = r_best_state;
  assign o_best_pm    = r_best_pm;
`else
  assign o_best_valid = 1'b0;
  assign o_best_state = '0;
  assign o_best_pm    = '0;
`endif

endmodule

// File: tb/tb_acs_array_64.sv
// tb_acs_array_64: directed table plus model-checked streams for acs_array_64.
module tb_acs_array_64;

  localparam int     TB_PM_W    = 6;
  localparam int     TB_PM_INIT = 16;
  localparam longint HALF       = longint'(1) << (TB_PM_W - 1);
`ifdef ACS64_BEST_STATE_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               init;
  logic               rx_valid;
  logic [1:0]         rx_pair;
  logic               dec_valid;
  logic [63:0]        dec_bits;
  logic               norm;
  logic               best_valid;
  logic [5:0]         best_state;
  logic [TB_PM_W-1:0] best_pm;

  int compareCount = 0;
  int failCount    = 0;

  longint     mPm [64];
  longint     mOffset;
  logic [63:0] mDec;
  logic       mNorm;
  longint     mBestPm;
  int         mBestState;
  logic       prevValid;

  typedef struct {
    logic       v;
    logic [1:0] rx;
    logic       expDecValid;
    logic       expDec0;
    logic       expNorm;
    logic [5:0] expBestState;
    int         expBestPm;
  } vec_t;

  vec_t tbl [4];
  logic bits [200];

  acs_array_64 #(.PM_W(TB_PM_W), .PM_INIT(TB_PM_INIT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_init       (init),
    .i_rx_valid   (rx_valid),
    .i_rx_pair    (rx_pair),
    .o_dec_valid  (dec_valid),
    .o_dec_bits   (dec_bits),
    .o_norm       (norm),
    .o_best_valid (best_valid),
    .o_best_state (best_state),
    .o_best_pm    (best_pm)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Encoder taps written out explicitly: G0 = 171 octal, G1 = 133 octal.
  function automatic logic [1:0] tbEnc(input logic [5:0] s, input logic u);
    logic [6:0] r;
    logic [1:0] c;
    r    = {u, s};
    c[0] = r[6] ^ r[5] ^ r[4] ^ r[3] ^ r[0];
    c[1] = r[6] ^ r[4] ^ r[3] ^ r[1] ^ r[0];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] rx, input logic in);
    rx_valid = v;
    rx_pair  = rx;
    init     = in;
  endtask

  // Lowest-index minimum of the register-domain metrics.
  task automatic modelBest();
    mBestPm    = mPm[0] - mOffset;
    mBestState = 0;
    for (int s = 1; s < 64; s++) begin
      if (mPm[s] - mOffset < mBestPm) begin
        mBestPm    = mPm[s] - mOffset;
        mBestState = s;
      end
    end
  endtask

  task automatic modelReset();
    mPm[0] = 0;
    for (int s = 1; s < 64; s++) mPm[s] = TB_PM_INIT;
    mOffset = 0;
    modelBest();
  endtask

  // Unbounded metrics; the offset tracks how much the hardware has subtracted.
  task automatic modelStep(input logic [1:0] rx);
    longint     nxt [64];
    longint     a0, a1, minV;
    int         p0, bm0, bm1;
    logic [1:0] c0, c1;
    for (int n = 0; n < 64; n++) begin
      p0  = (n % 32) * 2;
      c0  = tbEnc(6'(p0), n >= 32);
      c1  = tbEnc(6'(p0 + 1), n >= 32);
      bm0 = int'(rx[0] ^ c0[0]) + int'(rx[1] ^ c0[1]);
      bm1 = int'(rx[0] ^ c1[0]) + int'(rx[1] ^ c1[1]);
      a0  = mPm[p0] + bm0;
      a1  = mPm[p0 + 1] + bm1;
      mDec[n] = (a1 < a0);
      nxt[n]  = (a1 < a0) ? a1 : a0;
    end
    mPm  = nxt;
    minV = mPm[0] - mOffset;
    for (int s = 1; s < 64; s++) if (mPm[s] - mOffset < minV) minV = mPm[s] - mOffset;
    mNorm = (minV >= HALF);
    if (mNorm) mOffset += HALF;
    modelBest();
  endtask

  task automatic checkBest(input string tag, input logic bv, input logic [5:0] bs, input longint bp);
    checkOutput({tag, " best_valid"}, 64'(best_valid), BEST_EN ? 64'(bv) : 64'(0));
    checkOutput({tag, " best_state"}, 64'(best_state), BEST_EN ? 64'(bs) : 64'(0));
    checkOutput({tag, " best_pm"},    64'(best_pm),    BEST_EN ? 64'(bp) : 64'(0));
  endtask

  task automatic runSymbol(input logic v, input logic [1:0] rx, input string tag);
    logic       bv;
    logic [5:0] bs;
    longint     bp;
    bv = prevValid;
    bs = 6'(mBestState);
    bp = mBestPm;
    applyStimulus(v, rx, 1'b0);
    tick();
    if (v) modelStep(rx);
    checkOutput({tag, " dec_valid"}, 64'(dec_valid), 64'(v));
    if (v) begin
      checkOutput({tag, " dec_bits"}, dec_bits, mDec);
      checkOutput({tag, " norm"}, 64'(norm), 64'(mNorm));
    end else begin
      checkOutput({tag, " norm"}, 64'(norm), 64'(0));
    end
    checkBest(tag, bv, bs, bp);
    prevValid = v;
  endtask

  task automatic initPulse(input logic v, input logic [1:0] rx, input string tag);
    logic       bv;
    logic [5:0] bs;
    longint     bp;
    bv = prevValid;
    bs = 6'(mBestState);
    bp = mBestPm;
    applyStimulus(v, rx, 1'b1);
    tick();
    modelReset();
    checkOutput({tag, " dec_valid"}, 64'(dec_valid), 64'(0));
    checkOutput({tag, " norm"}, 64'(norm), 64'(0));
    checkBest(tag, bv, bs, bp);
    prevValid = 1'b0;
    init = 1'b0;
  endtask

  task automatic runEncoded(input logic flip);
    logic [5:0] encState;
    logic [1:0] c;
    string      tag;
    initPulse(1'b0, 2'b00, "enc init");
    encState = '0;
    for (int j = 0; j < 200; j++) begin
      c   = tbEnc(encState, bits[j]);
      tag = $sformatf("enc%0d[%0d]", flip, j);
      runSymbol(1'b1, (flip && j == 50) ? (c ^ 2'b01) : c, tag);
      checkOutput({tag, " path pm"}, 64'(best_pm),
                  BEST_EN ? ((flip && j >= 51) ? 64'(1) : 64'(0)) : 64'(0));
      if (j >= 6 && (!flip || j < 51 || j >= 57)) begin
        checkOutput({tag, " path state"}, 64'(best_state), BEST_EN ? 64'(encState) : 64'(0));
      end
      encState = {bits[j], encState[5:1]};
    end
  endtask

  initial begin
    int normSeen;

    tbl[0] = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 6'd32, 0};
    tbl[1] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 6'd32, 0};
    tbl[2] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 6'd16, 1};
    tbl[3] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 6'd40, 1};
    for (int i = 0; i < 200; i++) bits[i] = 1'($urandom_range(0, 1));

    rst_n = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'(i % 2), 2'(i), 1'b0);
      tick();
      checkOutput("reset dec_valid", 64'(dec_valid), 64'(0));
      checkOutput("reset dec_bits", dec_bits, 64'(0));
      checkOutput("reset norm", 64'(norm), 64'(0));
      checkOutput("reset best_valid", 64'(best_valid), 64'(0));
      checkOutput("reset best_state", 64'(best_state), 64'(0));
      checkOutput("reset best_pm", 64'(best_pm), 64'(0));
    end
    applyStimulus(1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("post-reset best_pm", 64'(best_pm), 64'(0));
    checkOutput("post-reset dec_valid", 64'(dec_valid), 64'(0));
    modelReset();
    prevValid = 1'b0;

    $display("[TB] directed table");
    for (int i = 0; i < 4; i++) begin
      runSymbol(tbl[i].v, tbl[i].rx, $sformatf("tbl[%0d]", i));
      checkOutput($sformatf("tbl[%0d] hand dec_valid", i), 64'(dec_valid), 64'(tbl[i].expDecValid));
      checkOutput($sformatf("tbl[%0d] hand dec0", i), 64'(dec_bits[0]), 64'(tbl[i].expDec0));
      checkOutput($sformatf("tbl[%0d] hand norm", i), 64'(norm), 64'(tbl[i].expNorm));
      runSymbol(1'b0, 2'b00, $sformatf("tbl[%0d] idle", i));
      checkBest($sformatf("tbl[%0d] hand", i), tbl[i].v, tbl[i].expBestState, longint'(tbl[i].expBestPm));
    end

    $display("[TB] all-zero stream");
    initPulse(1'b0, 2'b00, "zero init");
    for (int j = 0; j < 20; j++) begin
      runSymbol(1'b1, 2'b00, $sformatf("zero[%0d]", j));
      checkOutput($sformatf("zero[%0d] dec0", j), 64'(dec_bits[0]), 64'(0));
      checkOutput($sformatf("zero[%0d] norm", j), 64'(norm), 64'(0));
      checkOutput($sformatf("zero[%0d] best_pm", j), 64'(best_pm), 64'(0));
      checkOutput($sformatf("zero[%0d] best_state", j), 64'(best_state), 64'(0));
    end

    $display("[TB] encoded streams");
    runEncoded(1'b0);
    runEncoded(1'b1);

    $display("[TB] init with symbol");
    initPulse(1'b0, 2'b00, "initsym pre");
    for (int j = 0; j < 10; j++) runSymbol(1'b1, 2'($urandom_range(0, 3)), $sformatf("initsym[%0d]", j));
    initPulse(1'b1, 2'b10, "initsym[10]");
    runSymbol(1'b0, 2'b00, "initsym idle");
    checkOutput("initsym reset best_pm", 64'(best_pm), 64'(0));
    checkOutput("initsym reset best_state", 64'(best_state), 64'(0));
    runSymbol(1'b1, 2'b11, "initsym first");
    checkOutput("initsym first dec0", 64'(dec_bits[0]), 64'(0));
    runSymbol(1'b0, 2'b00, "initsym first idle");
    checkOutput("initsym first best_state", 64'(best_state), BEST_EN ? 64'(32) : 64'(0));

    $display("[TB] random uncoded stream");
    initPulse(1'b0, 2'b00, "rand init");
    normSeen = 0;
    for (int j = 0; j < 2000; j++) begin
      runSymbol(1'b1, 2'($urandom_range(0, 3)), $sformatf("rand[%0d]", j));
      if (norm === 1'b1) normSeen++;
    end
    checkOutput("norm pulsed", 64'(normSeen > 0), 64'(1));

    $display("[TB] reset mid-stream");
    rst_n = 1'b0;
    #2;
    checkOutput("midreset dec_valid", 64'(dec_valid), 64'(0));
    checkOutput("midreset best_valid", 64'(best_valid), 64'(0));
    checkOutput("midreset norm", 64'(norm), 64'(0));
    checkOutput("midreset dec_bits", dec_bits, 64'(0));
    applyStimulus(1'b0, 2'b00, 1'b0);
    tick();
    rst_n = 1'b1;
    modelReset();
    prevValid = 1'b0;
    runSymbol(1'b1, 2'b11, "after reset");
    runSymbol(1'b0, 2'b00, "after reset idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
